interfaz_memoria: RTL and testbench
===================================

INTERFAZ_MEMORIA -- requirements
Module: interfaz_memoria

Interface
REQ-001 SHALL have parameter ANCHO, default 16, data and address width in bits.
REQ-002 SHALL have parameter ESPERA_MAX, default 8, range 1..15, the maximum number of ACCESO cycles without MemAck before timeout.
REQ-003 SHALL have the following ports:
  Reloj  input  1  clock, rising edge.
  Reiniciar  input  1  reset, asynchronous, active-low.
  Solicitud  input  1  memory command request from the control unit.
  Escribir  input  1  1 = write, 0 = read; sampled with Solicitud.
  DireccionIn  input  ANCHO  address, from AR.
  DatoIn  input  ANCHO  write data, from DR.
  DatoOut  output  ANCHO  read data, to DR/IR.
  Ocupado  output  1  transaction in progress.
  Listo  output  1  one-cycle completion pulse.
  Error  output  1  one-cycle timeout pulse.
  MemDir  output  ANCHO  external memory address.
  MemDatoEsc  output  ANCHO  external write data.
  MemDatoLec  input  ANCHO  external read data.
  MemLeer  output  1  external read strobe.
  MemEscribir  output  1  external write strobe.
  MemAck  input  1  external access acknowledge.

Function
REQ-004 SHALL implement a registered FSM with states REPOSO, ACCESO, FIN and FALLA; all outputs SHALL be registered or decoded from state only.
REQ-005 In REPOSO, Solicitud SHALL be sampled at each rising edge; if it is 1, the block SHALL capture DireccionIn, DatoIn and Escribir into internal registers, clear the wait counter and enter ACCESO.
REQ-006 Solicitud SHALL be ignored in ACCESO, FIN and FALLA; a request is accepted only when sampled in REPOSO.
REQ-007 ACCESO SHALL drive Ocupado=1 and MemDir = captured address.
REQ-008 In ACCESO, MemLeer SHALL equal the negation of captured Escribir, and MemEscribir SHALL equal captured Escribir.
REQ-009 In ACCESO, MemDatoEsc SHALL equal the captured data for writes and 0 for reads.
REQ-010 In ACCESO, if MemAck=1 at an edge, the block SHALL enter FIN; on a read, it SHALL load MemDatoLec into DatoOut at that same edge.
REQ-011 In ACCESO, each edge with MemAck=0 SHALL increment the 4-bit wait counter.
REQ-012 When the counter already equals ESPERA_MAX-1 and MemAck=0 at an edge, the block SHALL enter FALLA.
REQ-013 If MemAck=1 occurs at the same edge the timeout would fire, MemAck SHALL win and the next state SHALL be FIN.
REQ-014 FIN SHALL last exactly one cycle with Listo=1, Ocupado=0, both strobes 0 and MemDir held; it SHALL then return to REPOSO.
REQ-015 FALLA SHALL last exactly one cycle with Listo=1, Error=1, both strobes 0 and DatoOut unchanged; it SHALL then return to REPOSO.
REQ-016 Latency SHALL be as follows: request accepted at edge k gives strobe high during cycle k+1.
REQ-017 With MemAck sampled high at edge k+1+w (w = 0..ESPERA_MAX-1), Listo SHALL be high for the single cycle following that edge.
REQ-018 Minimum request-to-Listo latency SHALL be 2 edges.
REQ-019 MemAck SHALL be ignored outside ACCESO.
REQ-020 DatoOut SHALL change only on a read completing in ACCESO; writes and timeouts SHALL leave it unchanged.
REQ-021 MemLeer and MemEscribir SHALL never be 1 simultaneously.

Reset
REQ-022 Reiniciar=0 SHALL immediately force state REPOSO, all outputs and internal registers to 0, and the wait counter to 0, independent of Reloj.
REQ-023 A reset asserted mid-transaction SHALL drop the strobes asynchronously and SHALL produce no Listo or Error pulse afterwards.
REQ-024 After Reiniciar returns to 1, the first request SHALL be accepted no earlier than the first subsequent rising edge.

Verification
REQ-025 Read, zero wait: DireccionIn=0x0040, Escribir=0, Solicitud pulse, MemAck=1 next edge, MemDatoLec=0xBEEF -> MemLeer high 1 cycle, MemDir=0x0040, Listo 1 cycle, DatoOut=0xBEEF.
REQ-026 Write, 3 waits: DireccionIn=0x1234, DatoIn=0x00FF, Escribir=1, MemAck high after 3 low cycles -> MemEscribir high 4 cycles, MemDatoEsc=0x00FF, Listo 1 cycle, DatoOut unchanged.
REQ-027 Timeout: read with MemAck held 0 -> MemLeer high exactly 8 cycles, then Listo=1 and Error=1 for 1 cycle, then REPOSO.
REQ-028 Ack on last wait cycle: MemAck=1 at the 8th ACCESO edge -> FIN, no Error, read data captured.
REQ-029 Ignored inputs: Solicitud held high continuously and MemAck pulsed while in REPOSO -> back-to-back transactions start only from REPOSO with a FIN cycle between them; stray MemAck has no effect.
REQ-030 Reset mid-access: Reiniciar=0 during ACCESO -> strobes 0 within the same cycle, DatoOut=0, no Listo after release.

Source files
------------

// File: rtl/interfaz_memoria.sv
`default_nettype none
// ============================================================================
//  Module   : interfaz_memoria
//  Purpose  : Single-request memory access sequencer with ack wait and timeout.
//  Revision : 1.0  initial release
// ============================================================================
module interfaz_memoria #(
    parameter int ANCHO      = 16,
    parameter int ESPERA_MAX = 8
) (
    input  logic             Reloj,
    input  logic             Reiniciar,
    input  logic             Solicitud,
    input  logic             Escribir,
    input  logic [ANCHO-1:0] DireccionIn,
    input  logic [ANCHO-1:0] DatoIn,
    output logic [ANCHO-1:0] DatoOut,
    output logic             Ocupado,
    output logic             Listo,
    output logic             Error,
    output logic [ANCHO-1:0] MemDir,
    output logic [ANCHO-1:0] MemDatoEsc,
    input  logic [ANCHO-1:0] MemDatoLec,
    output logic             MemLeer,
    output logic             MemEscribir,
    input  logic             MemAck
);

    localparam logic [1:0] REPOSO = 2'd0;
    localparam logic [1:0] ACCESO = 2'd1;
    localparam logic [1:0] FIN    = 2'd2;
    localparam logic [1:0] FALLA  = 2'd3;

    localparam logic [3:0] C_ULTIMA_ESPERA = 4'(ESPERA_MAX - 1);

    logic [1:0]       estado_q,    estado_d;
    logic [3:0]       espera_q,    espera_d;
    logic             escribir_q,  escribir_d;
    logic [ANCHO-1:0] dir_q,       dir_d;
    logic [ANCHO-1:0] dato_esc_q,  dato_esc_d;
    logic [ANCHO-1:0] dato_lec_q,  dato_lec_d;

    always_comb begin
        estado_d   = estado_q;
        espera_d   = espera_q;
        escribir_d = escribir_q;
        dir_d      = dir_q;
        dato_esc_d = dato_esc_q;
        dato_lec_d = dato_lec_q;
        case (estado_q)
            REPOSO: begin
                if (Solicitud) begin
                    dir_d      = DireccionIn;
                    dato_esc_d = DatoIn;
                    escribir_d = Escribir;
                    espera_d   = 4'd0;
                    estado_d   = ACCESO;
                end
            end
            ACCESO: begin
                // An ack on the final wait edge still completes normally.
                if (MemAck) begin
                    estado_d = FIN;
                    if (!escribir_q) begin
                        dato_lec_d = MemDatoLec;
                    end
                end else begin
                    espera_d = espera_q + 4'd1;
                    if (espera_q == C_ULTIMA_ESPERA) begin
                        estado_d = FALLA;
                    end
                end
            end
            FIN:     estado_d = REPOSO;
            FALLA:   estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            estado_q   <= REPOSO;
            espera_q   <= 4'd0;
            escribir_q <= 1'b0;
            dir_q      <= '0;
            dato_esc_q <= '0;
            dato_lec_q <= '0;
        end else begin
            estado_q   <= estado_d;
            espera_q   <= espera_d;
            escribir_q <= escribir_d;
            dir_q      <= dir_d;
            dato_esc_q <= dato_esc_d;
            dato_lec_q <= dato_lec_d;
        end
    end

    // Strobes decode from state so an asynchronous reset removes them at once.
    assign Ocupado     = (estado_q == ACCESO);
    assign Listo       = (estado_q == FIN) || (estado_q == FALLA);
    assign Error       = (estado_q == FALLA);
    assign MemLeer     = (estado_q == ACCESO) && !escribir_q;
    assign MemEscribir = (estado_q == ACCESO) &&  escribir_q;
    assign MemDatoEsc  = ((estado_q == ACCESO) && escribir_q) ? dato_esc_q : '0;
    assign MemDir      = dir_q;
    assign DatoOut     = dato_lec_q;

endmodule
`default_nettype wire

// File: tb/tb_interfaz_memoria.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interfaz_memoria
//  Purpose  : Self-checking bench: vector table, scoreboard and corner cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_interfaz_memoria;

    logic        clk;
    logic        rst_n;
    logic        Solicitud, Escribir, MemAck;
    logic [15:0] DireccionIn, DatoIn, MemDatoLec;
    logic [15:0] DatoOut, MemDir, MemDatoEsc;
    logic        Ocupado, Listo, Error, MemLeer, MemEscribir;

    interfaz_memoria #(.ANCHO(16), .ESPERA_MAX(8)) dut (
        .Reloj       (clk),
        .Reiniciar   (rst_n),
        .Solicitud   (Solicitud),
        .Escribir    (Escribir),
        .DireccionIn (DireccionIn),
        .DatoIn      (DatoIn),
        .DatoOut     (DatoOut),
        .Ocupado     (Ocupado),
        .Listo       (Listo),
        .Error       (Error),
        .MemDir      (MemDir),
        .MemDatoEsc  (MemDatoEsc),
        .MemDatoLec  (MemDatoLec),
        .MemLeer     (MemLeer),
        .MemEscribir (MemEscribir),
        .MemAck      (MemAck)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        esc;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;        // ack-low edges before ack; >= 8 means timeout
        int          exp_strobes;
        logic        exp_err;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t tbl [7];
    vec_t sb [$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic run_txn(input vec_t v);
        int   n;
        bit   done;
        vec_t e;
        n    = 0;
        done = 1'b0;
        @(negedge clk);
        Solicitud   = 1'b1;
        Escribir    = v.esc;
        DireccionIn = v.addr;
        DatoIn      = v.wdata;
        MemAck      = 1'b0;
        sb.push_back(v);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            Solicitud = 1'b0;
            if (Listo) begin
                done = 1'b1;
            end else begin
                n++;
                chk("mem_leer",     MemLeer,     !v.esc);
                chk("mem_escribir", MemEscribir, v.esc);
                chk("mem_dir",      MemDir,      v.addr);
                chk("mem_dato_esc", MemDatoEsc,  v.esc ? v.wdata : 16'h0000);
                chk("ocupado",      Ocupado,     1'b1);
                MemAck     = (n == v.waits + 1);
                MemDatoLec = v.rdata;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL listo_timeout: got no Listo expected Listo within 40 cycles");
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("strobe_cycles", n,           e.exp_strobes);
            chk("error",         Error,       e.exp_err);
            chk("dato_out",      DatoOut,     e.exp_dout);
            chk("fin_strobes",   {MemLeer, MemEscribir}, 2'b00);
            chk("fin_ocupado",   Ocupado,     1'b0);
            chk("fin_mem_dir",   MemDir,      e.addr);
            MemAck = 1'b0;
            @(negedge clk);
            chk("listo_pulse",   Listo,       1'b0);
            chk("error_pulse",   Error,       1'b0);
        end
    endtask

    logic exp_leer [6];
    logic exp_listo[6];
    vec_t rec;

    initial begin
        tbl[0] = '{1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 1, 1'b0, 16'hBEEF};
        tbl[1] = '{1'b1, 16'h1234, 16'h00FF, 16'hDEAD, 3, 4, 1'b0, 16'hBEEF};
        tbl[2] = '{1'b0, 16'h0A0A, 16'h0000, 16'h1111, 8, 8, 1'b1, 16'hBEEF};
        tbl[3] = '{1'b0, 16'h0F0F, 16'h0000, 16'hCAFE, 7, 8, 1'b0, 16'hCAFE};
        tbl[4] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h9999, 0, 1, 1'b0, 16'hCAFE};
        tbl[5] = '{1'b0, 16'h0001, 16'h0000, 16'h0000, 2, 3, 1'b0, 16'h0000};
        tbl[6] = '{1'b1, 16'h8000, 16'h1234, 16'h4321, 8, 8, 1'b1, 16'h0000};
        exp_leer  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_listo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        Solicitud = 1'b0; Escribir = 1'b0; MemAck = 1'b0;
        DireccionIn = 16'h0; DatoIn = 16'h0; MemDatoLec = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {Ocupado, Listo, Error, MemLeer, MemEscribir}, 5'b0);
        chk("rst_dato_out", DatoOut, 16'h0);
        chk("rst_mem_dir", MemDir, 16'h0);
        chk("rst_mem_dato_esc", MemDatoEsc, 16'h0);
        rst_n = 1'b1;

        // Stray ack while idle must do nothing.
        MemAck = 1'b1; MemDatoLec = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_ack_idle", {Ocupado, Listo, Error, MemLeer}, 4'b0);
            chk("stray_ack_dato", DatoOut, 16'h0);
        end
        MemAck = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Solicitud and MemAck held high: A F R A F R cadence.
        @(negedge clk);
        Solicitud = 1'b1; Escribir = 1'b0; MemAck = 1'b1; MemDatoLec = 16'h7777;
        DireccionIn = 16'h0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_req_leer",  MemLeer, exp_leer[i]);
            chk("held_req_listo", Listo,   exp_listo[i]);
        end
        Solicitud = 1'b0; MemAck = 1'b0;
        chk("held_req_dato", DatoOut, 16'h7777);

        // Reset in the middle of an access.
        @(negedge clk);
        Solicitud = 1'b1; Escribir = 1'b0; DireccionIn = 16'h0200; MemDatoLec = 16'h5555;
        @(negedge clk);
        Solicitud = 1'b0;
        chk("mid_rst_pre_leer", MemLeer, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_leer",    MemLeer, 1'b0);
        chk("mid_rst_ocupado", Ocupado, 1'b0);
        chk("mid_rst_dato",    DatoOut, 16'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        MemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {Listo, Error, Ocupado}, 3'b0);
        end
        MemAck = 1'b0;

        rec = '{1'b0, 16'h0300, 16'h0000, 16'h4242, 1, 2, 1'b0, 16'h4242};
        run_txn(rec);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish by 50000");
        $fatal(1);
    end

endmodule
`default_nettype wire
